gpio_port: RTL and testbench

Parametrised, buffered bidirectional GPIO peripheral on the 16-bit memory-mapped bus. It is the successor to the single-direction output block. It provides `size` 16-bit channels, each with:

- per-bit direction control;
- atomic set/clear/toggle aliases;
- synchronised input readback;
- edge-triggered, sticky interrupt flags, combined onto one `irq` line.

---
 rtl/gpio_port_pkg.sv | 19 +
 rtl/gpio_port_if.sv | 26 ++
 rtl/gpio_port_sync.sv | 52 +++++
 rtl/gpio_port.sv | 150 +++++++++++++++
 tb/tb_gpio_port.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_port_pkg.sv
// Shared constants for the gpio_port peripheral: data width and the
// per-channel register map.
package gpio_pkg;

    localparam int DATA_W = 16;

    // Register offsets within one channel (address bits [2:0]).
    typedef enum logic [2:0] {
        GPIO_OUT = 3'd0,
        GPIO_SET = 3'd1,
        GPIO_CLR = 3'd2,
        GPIO_TGL = 3'd3,
        GPIO_DIR = 3'd4,
        GPIO_IN  = 3'd5,
        GPIO_IE  = 3'd6,
        GPIO_IP  = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_port_if.sv
// Memory-mapped bus between a host and gpio_port: one-cycle read/write
// strobes, {channel, reg} address, 16-bit data and per-direction ready.
interface gpio_port_if #(
    parameter int size_addr = 0
);
    import gpio_pkg::*;

    logic                read;
    logic                write;
    logic                ready_r;
    logic                ready_w;
    logic [size_addr+2:0] address;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;

    modport master (
        output read, write, address, data_in,
        input  ready_r, ready_w, data_out
    );

    modport slave (
        input  read, write, address, data_in,
        output ready_r, ready_w, data_out
    );

endinterface

// File: rtl/gpio_port_sync.sv
// Per-channel input synchroniser with edge detection. Edges are held off
// until the pipeline and history register contain only post-reset samples,
// so pins that sit high through reset never look like an edge.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int sync_stages = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pin_in,
    output logic [DATA_W-1:0] sync_out,
    output logic [DATA_W-1:0] edges
);

    localparam logic [2:0] PRIME_DONE = 3'(sync_stages + 1);

    logic [DATA_W-1:0] stage_r [sync_stages];
    logic [DATA_W-1:0] prev_r;
    logic [2:0]        prime_r;

    // Shift pins through the synchroniser and keep the previous output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < sync_stages; i++) begin
                stage_r[i] <= 16'h0000;
            end
            prev_r  <= 16'h0000;
            prime_r <= 3'd0;
        end else begin
            stage_r[0] <= pin_in;
            for (int i = 1; i < sync_stages; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            prev_r <= stage_r[sync_stages-1];
            if (prime_r != PRIME_DONE) begin
                prime_r <= prime_r + 3'd1;
            end
        end
    end

    // Any change of the synchronised value is an edge once primed.
    always_comb begin
        sync_out = stage_r[sync_stages-1];
        if (prime_r == PRIME_DONE) begin
            edges = sync_out ^ prev_r;
        end else begin
            edges = 16'h0000;
        end
    end

endmodule

// File: rtl/gpio_port.sv
// Buffered bidirectional GPIO: `size` 16-bit channels with direction,
// set/clear/toggle aliases, synchronised inputs and sticky edge interrupts.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int          size        = 1,
    parameter int          size_addr   = 0,
    parameter int          sync_stages = 2,
    parameter logic [15:0] out_reset   = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    gpio_port_if.slave             bus,
    input  logic [size*DATA_W-1:0] port_in,
    output logic [size*DATA_W-1:0] port_out,
    output logic [size*DATA_W-1:0] port_oe,
    output logic                   irq
);

    logic [DATA_W-1:0] out_r  [size];
    logic [DATA_W-1:0] dir_r  [size];
    logic [DATA_W-1:0] ie_r   [size];
    logic [DATA_W-1:0] ip_r   [size];
    logic [DATA_W-1:0] sync_s [size];
    logic [DATA_W-1:0] edge_s [size];

    logic [31:0]       chan_s;
    logic              chan_ok_s;
    gpio_reg_e         reg_s;
    logic [size-1:0]   wr_hit_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              irq_s;

    logic [DATA_W-1:0] data_out_r;
    logic              ready_r_r;
    logic              ready_w_r;
    logic              irq_r;

    // Value a read of register `sel` returns for one channel.
    function automatic logic [DATA_W-1:0] reg_view(
        input gpio_reg_e         sel,
        input logic [DATA_W-1:0] out_v,
        input logic [DATA_W-1:0] dir_v,
        input logic [DATA_W-1:0] in_v,
        input logic [DATA_W-1:0] ie_v,
        input logic [DATA_W-1:0] ip_v
    );
        logic [DATA_W-1:0] v;
        case (sel)
            GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: v = out_v;
            GPIO_DIR: v = dir_v;
            GPIO_IN:  v = in_v;
            GPIO_IE:  v = ie_v;
            GPIO_IP:  v = ip_v;
            default:  v = 16'h0000;
        endcase
        return v;
    endfunction

    // Channel field is absent when size_addr is 0: channel 0 only.
    if (size_addr > 0) begin : g_chan
        assign chan_s = 32'(bus.address[size_addr+2:3]);
    end else begin : g_chan0
        assign chan_s = 32'd0;
    end

    assign reg_s     = gpio_reg_e'(bus.address[2:0]);
    assign chan_ok_s = (chan_s < 32'(size));

    for (genvar g = 0; g < size; g++) begin : g_ch
        gpio_sync #(
            .sync_stages (sync_stages)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .pin_in   (port_in[DATA_W*g +: DATA_W]),
            .sync_out (sync_s[g]),
            .edges    (edge_s[g])
        );
        assign port_out[DATA_W*g +: DATA_W] = out_r[g];
        assign port_oe[DATA_W*g +: DATA_W]  = dir_r[g];
    end

    // Decode write target, read mux (pre-write values) and interrupt OR.
    always_comb begin
        wr_hit_s  = '0;
        rd_data_s = 16'h0000;
        irq_s     = 1'b0;
        for (int i = 0; i < size; i++) begin
            wr_hit_s[i] = bus.write && chan_ok_s && (chan_s == 32'(i));
            rd_data_s   = rd_data_s |
                          ((chan_ok_s && (chan_s == 32'(i))) ?
                           reg_view(reg_s, out_r[i], dir_r[i], sync_s[i], ie_r[i], ip_r[i]) :
                           16'h0000);
            irq_s       = irq_s | (|(ip_r[i] & ie_r[i]));
        end
    end

    // Register file: bus writes plus edge capture; a new edge beats W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < size; i++) begin
                out_r[i] <= out_reset;
                dir_r[i] <= 16'h0000;
                ie_r[i]  <= 16'h0000;
                ip_r[i]  <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                if (wr_hit_s[i]) begin
                    case (reg_s)
                        GPIO_OUT: out_r[i] <= bus.data_in;
                        GPIO_SET: out_r[i] <= out_r[i] | bus.data_in;
                        GPIO_CLR: out_r[i] <= out_r[i] & ~bus.data_in;
                        GPIO_TGL: out_r[i] <= out_r[i] ^ bus.data_in;
                        GPIO_DIR: dir_r[i] <= bus.data_in;
                        GPIO_IE:  ie_r[i]  <= bus.data_in;
                        default:  ;
                    endcase
                end
                ip_r[i] <= (ip_r[i] &
                            ~((wr_hit_s[i] && (reg_s == GPIO_IP)) ? bus.data_in : 16'h0000)) |
                           (edge_s[i] & ie_r[i]);
            end
        end
    end

    // Registered bus responses and interrupt line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r <= 16'h0000;
            ready_r_r  <= 1'b0;
            ready_w_r  <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (bus.read) begin
                data_out_r <= rd_data_s;
            end
            ready_r_r <= bus.read;
            ready_w_r <= bus.write;
            irq_r     <= irq_s;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.ready_r  = ready_r_r;
    assign bus.ready_w  = ready_w_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed table, hand-timed interrupt
// sequences, randomized traffic against a register-level model, and reset.
module tb_gpio_port;
    import gpio_pkg::*;

    localparam int          SIZE  = 2;
    localparam int          SADDR = 2;
    localparam int          S     = 2;
    localparam logic [15:0] ORST  = 16'hA5A5;
    localparam int          PW    = SIZE * 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] port_in;
    logic [PW-1:0] port_out;
    logic [PW-1:0] port_oe;
    logic          irq;

    gpio_port_if #(.size_addr(SADDR)) bus_if ();

    gpio_port #(
        .size        (SIZE),
        .size_addr   (SADDR),
        .sync_stages (S),
        .out_reset   (ORST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .port_in  (port_in),
        .port_out (port_out),
        .port_oe  (port_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus a history of sampled pins.
    logic [15:0]   m_out [SIZE];
    logic [15:0]   m_dir [SIZE];
    logic [15:0]   m_ie  [SIZE];
    logic [15:0]   m_ip  [SIZE];
    logic [PW-1:0] ph    [S+1];
    int            n_edges;
    logic [15:0]   m_dout;
    logic          m_rr, m_rw, m_irq;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_out;
        logic [15:0] exp_dout;
        bit          chk_dout;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input int c, input int r);
        if (c >= SIZE) return 16'h0000;
        case (r)
            0, 1, 2, 3: return m_out[c];
            4:          return m_dir[c];
            5:          return ph[S-1][16*c +: 16];
            6:          return m_ie[c];
            7:          return m_ip[c];
            default:    return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < SIZE; c++) begin
            m_out[c] = ORST;
            m_dir[c] = 16'h0000;
            m_ie[c]  = 16'h0000;
            m_ip[c]  = 16'h0000;
        end
        for (int j = 0; j <= S; j++) ph[j] = '0;
        n_edges = 0;
        m_dout  = 16'h0000;
        m_rr    = 1'b0;
        m_rw    = 1'b0;
        m_irq   = 1'b0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [4:0] a,
                              input logic [15:0] d, input logic [PW-1:0] pins);
        int          c;
        int          r;
        logic        irq_n;
        logic [15:0] ev;
        logic [15:0] set_v;
        logic [15:0] clr_v;
        c     = int'(a[4:3]);
        r     = int'(a[2:0]);
        irq_n = 1'b0;
        if (rd) m_dout = m_read(c, r);
        m_rr = rd;
        m_rw = wr;
        for (int k = 0; k < SIZE; k++) irq_n = irq_n | (|(m_ip[k] & m_ie[k]));
        for (int k = 0; k < SIZE; k++) begin
            ev    = (n_edges >= S + 1) ? (ph[S-1][16*k +: 16] ^ ph[S][16*k +: 16]) : 16'h0000;
            set_v = ev & m_ie[k];
            clr_v = (wr && c == k && r == 7) ? d : 16'h0000;
            if (wr && c == k) begin
                case (r)
                    0: m_out[k] = d;
                    1: m_out[k] = m_out[k] | d;
                    2: m_out[k] = m_out[k] & ~d;
                    3: m_out[k] = m_out[k] ^ d;
                    4: m_dir[k] = d;
                    6: m_ie[k]  = d;
                    default: ;
                endcase
            end
            m_ip[k] = (m_ip[k] & ~clr_v) | set_v;
        end
        for (int j = S; j > 0; j--) ph[j] = ph[j-1];
        ph[0] = pins;
        n_edges++;
        m_irq = irq_n;
    endtask

    // One bus cycle: drive, clock, advance model, compare all outputs.
    task automatic cycle(input bit rd, input bit wr, input logic [4:0] a, input logic [15:0] d);
        bus_if.read    = rd;
        bus_if.write   = wr;
        bus_if.address = a;
        bus_if.data_in = d;
        @(posedge clk);
        model_edge(rd, wr, a, d, port_in);
        #1;
        chk("port_out", port_out, {m_out[1], m_out[0]});
        chk("port_oe", port_oe, {m_dir[1], m_dir[0]});
        chk("irq", 32'(irq), 32'(m_irq));
        chk("ready_r", 32'(bus_if.ready_r), 32'(m_rr));
        chk("ready_w", 32'(bus_if.ready_w), 32'(m_rw));
        chk("data_out", 32'(bus_if.data_out), 32'(m_dout));
        bus_if.read  = 1'b0;
        bus_if.write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 16'h0000);
    endtask

    initial begin
        bus_if.read    = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.address = 5'd0;
        bus_if.data_in = 16'h0000;
        port_in        = '0;
        model_reset();

        tbl[0]  = '{1'b1, 1'b0, 5'd0,  16'h0000, 16'hA5A5, 16'hA5A5, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 5'd0,  16'h00F0, 16'h00F0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 5'd1,  16'h000F, 16'h00FF, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd2,  16'h0030, 16'h00CF, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 5'd3,  16'hFF00, 16'hFFCF, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'd3,  16'h0000, 16'hFFCF, 16'hFFCF, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 5'd4,  16'h0F0F, 16'hFFCF, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 5'd4,  16'h0000, 16'hFFCF, 16'h0F0F, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 5'd0,  16'h1111, 16'h1111, 16'hFFCF, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 5'd5,  16'hFFFF, 16'h1111, 16'h0000, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd5,  16'h0000, 16'h1111, 16'h0000, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 5'd16, 16'h1234, 16'h1111, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 5'd16, 16'h0000, 16'h1111, 16'h0000, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 5'd8,  16'h0000, 16'h1111, 16'hA5A5, 1'b1};

        // Reset state, then release away from the clock edge.
        #12;
        chk("rst_port_out", port_out, {16'hA5A5, 16'hA5A5});
        chk("rst_port_oe", port_oe, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_data_out", 32'(bus_if.data_out), 32'h0);
        chk("rst_ready_r", 32'(bus_if.ready_r), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed register table.
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_out", i), 32'(port_out[15:0]), 32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_rdy_r", i), 32'(bus_if.ready_r), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_rdy_w", i), 32'(bus_if.ready_w), 32'(tbl[i].wr));
            if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), 32'(bus_if.data_out), 32'(tbl[i].exp_dout));
        end

        // Input synchroniser latency on channel 1.
        port_in[31:16] = 16'h1234;
        cycle(1'b1, 1'b0, 5'b01101, 16'h0000);
        chk("sync_e1", 32'(bus_if.data_out), 32'h0);
        cycle(1'b1, 1'b0, 5'b01101, 16'h0000);
        chk("sync_e2", 32'(bus_if.data_out), 32'h0);
        cycle(1'b1, 1'b0, 5'b01101, 16'h0000);
        chk("sync_e3", 32'(bus_if.data_out), 32'h1234);
        cycle(1'b1, 1'b0, 5'b11101, 16'h0000);
        chk("bad_chan_rd", 32'(bus_if.data_out), 32'h0);
        chk("bad_chan_rdy", 32'(bus_if.ready_r), 32'h1);

        // Interrupt on bit 0: IP at edge 3, irq at edge 4.
        cycle(1'b0, 1'b1, 5'b00110, 16'h0001);
        port_in[0] = 1'b1;
        idle(2);
        cycle(1'b0, 1'b0, 5'd0, 16'h0000);
        chk("irq_e3", 32'(irq), 32'h0);
        cycle(1'b1, 1'b0, 5'b00111, 16'h0000);
        chk("ip_e4", 32'(bus_if.data_out), 32'h0001);
        chk("irq_e4", 32'(irq), 32'h1);
        // Edge on a disabled bit is discarded.
        port_in[1] = 1'b1;
        idle(4);
        cycle(1'b1, 1'b0, 5'b00111, 16'h0000);
        chk("ip_masked", 32'(bus_if.data_out), 32'h0001);
        // W1C drops irq one edge later.
        cycle(1'b0, 1'b1, 5'b00111, 16'h0001);
        cycle(1'b0, 1'b0, 5'd0, 16'h0000);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Set wins over a simultaneous W1C.
        port_in[0] = 1'b0;
        idle(4);
        chk("irq_pre_race", 32'(irq), 32'h1);
        port_in[0] = 1'b1;
        idle(2);
        cycle(1'b0, 1'b1, 5'b00111, 16'h0001);
        cycle(1'b1, 1'b0, 5'b00111, 16'h0000);
        chk("setwins_ip", 32'(bus_if.data_out), 32'h0001);
        chk("setwins_irq", 32'(irq), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) port_in = PW'({$urandom, $urandom});
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 16'($urandom));
        end

        // Reset in the middle of a DIR write.
        cycle(1'b0, 1'b1, 5'b00100, 16'hFFFF);
        cycle(1'b1, 1'b0, 5'b00100, 16'h0000);
        port_in        = '1;
        bus_if.write   = 1'b1;
        bus_if.address = 5'b00100;
        bus_if.data_in = 16'h0F0F;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_oe", port_oe, 32'h0);
        chk("mid_rst_ready_w", 32'(bus_if.ready_w), 32'h0);
        chk("mid_rst_dout", 32'(bus_if.data_out), 32'h0);
        chk("mid_rst_out", port_out, {16'hA5A5, 16'hA5A5});
        bus_if.write = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 1'b1, 5'b00110, 16'hFFFF);
        cycle(1'b0, 1'b1, 5'b01110, 16'hFFFF);
        idle(6);
        cycle(1'b1, 1'b0, 5'b00111, 16'h0000);
        chk("post_rst_ip0", 32'(bus_if.data_out), 32'h0);
        cycle(1'b1, 1'b0, 5'b01111, 16'h0000);
        chk("post_rst_ip1", 32'(bus_if.data_out), 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
